way_select_plru: RTL
====================

WAY_SELECT_PLRU -- requirements
Module: way_select_plru

Interface
REQ-001 The block SHALL have parameter CACHE_WAY, default 4, meaning the number of ways; legal values are 2, 4 and 8.
REQ-002 The block SHALL have parameter RAM_DEPTH, default 256, meaning the number of sets; it SHALL be a power of two.
REQ-003 The block SHALL have parameter RAM_DEPTH_LOG, default 8, meaning log2(RAM_DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port addr, input, RAM_DEPTH_LOG bits: the set index for both lookup and update.
REQ-007 The block SHALL have port hit, input, CACHE_WAY bits: one-hot hit vector for the access.
REQ-008 The block SHALL have port way_sel_update, input, 1 bit: commits hit as most recently used in set addr.
REQ-009 The block SHALL have port refill, input, 1 bit: commits refill_way as most recently used in set addr.
REQ-010 The block SHALL have port refill_way, input, CACHE_WAY bits: one-hot way just filled.
REQ-011 The block SHALL have port way_valid, input, CACHE_WAY bits: valid bits of set addr, read from the tag RAM.
REQ-012 The block SHALL have port way_sel, output, CACHE_WAY bits: one-hot victim way for set addr.
REQ-013 The block SHALL have port way_sel_idx, output, log2(CACHE_WAY) bits: binary index of way_sel.
REQ-014 The block SHALL have port onehot_err, output, 1 bit: sticky flag for a malformed update vector.

Function
REQ-015 Each set SHALL hold CACHE_WAY-1 tree-PLRU bits.
  - Node 0 is the root; node i has children 2i+1 and 2i+2.
  - Leaf order is way 0 to way CACHE_WAY-1, left to right.
  - Bit value 0 points the victim search to the left (lower) subtree.
REQ-016 Victim lookup SHALL be combinational from addr.
  - Walk from the root, following the stored bits, to reach the PLRU way.
  - way_sel and way_sel_idx are valid in the same cycle as addr.
REQ-017 If any way_valid bit is 0, way_sel SHALL select the lowest-index invalid way instead of the PLRU way.
REQ-018 way_sel SHALL always be exactly one-hot, and way_sel_idx SHALL always match it.
REQ-019 On a rising edge with way_sel_update=1 and hit one-hot, every tree bit on the path to the hit way SHALL be written to point away from it.
  - Leftward path node written 1; rightward path node written 0.
  - All other bits are unchanged.
REQ-020 A refill with refill_way one-hot SHALL update the tree exactly as in REQ-019, using refill_way.
REQ-021 If refill and way_sel_update are both 1 in the same cycle, refill SHALL win and the hit update SHALL be dropped.
REQ-022 way_sel_update with hit=0 SHALL leave the state unchanged and SHALL NOT raise an error.
REQ-023 A multi-hot hit (when hit wins) or a multi-hot or zero refill_way (when refill=1) SHALL leave the state unchanged and set onehot_err=1.
  - onehot_err stays 1 until reset.
REQ-024 A lookup in the same cycle as an update to the same set SHALL show the pre-update state; the new state is visible from the next cycle.
REQ-025 Write latency SHALL be 1 cycle, and the block SHALL accept back-to-back updates every cycle with no stall.
REQ-026 With CACHE_WAY=2, behaviour SHALL be:
  - hit=01 then lookup gives way_sel=10;
  - hit=10 then lookup gives way_sel=01.

Reset
REQ-027 While rstn=0, all tree bits in all sets SHALL be 0 and onehot_err SHALL be 0, asynchronously.
REQ-028 After reset with all ways valid, every set SHALL select way 0.
REQ-029 Deasserting rstn SHALL take effect at the next clk edge; an update on that edge SHALL be applied.
REQ-030 Asserting rstn mid-stream SHALL discard any update in progress.

Verification (CACHE_WAY=4)
REQ-031 Reset, way_valid=1111, addr=5 -> way_sel=0001, way_sel_idx=0; repeat for addr=0 and addr=255.
REQ-032 Set 5, all valid: hit 0001, 0010, 0100, 1000 on consecutive cycles -> way_sel=0001; then hit 0001 -> way_sel=0100.
REQ-033 Set 7, way_valid=1011 with any tree state -> way_sel=0100; way_valid=0000 -> way_sel=0001.
REQ-034 Same cycle, set 9: refill=1, refill_way=0001, way_sel_update=1, hit=0100 -> the next cycle shows way_sel=0100, with only refill applied; onehot_err=0.
REQ-035 hit=0110 with way_sel_update=1 -> state unchanged and onehot_err=1; it stays 1 across later legal updates and clears only when rstn=0.
REQ-036 Lookup in the same cycle as an update to the same set -> old way_sel; updates to set 3 -> way_sel for set 4 unchanged.

Source files
------------

// File: rtl/way_select_plru.sv
// Tree pseudo-LRU victim selection for a set-associative cache.
// Combinational lookup per set; hit/refill updates commit on the next rising edge.
module way_select_plru #(
    parameter int CACHE_WAY     = 4,
    parameter int RAM_DEPTH     = 256,
    parameter int RAM_DEPTH_LOG = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [RAM_DEPTH_LOG-1:0]     addr,
    input  logic [CACHE_WAY-1:0]         hit,
    input  logic                         way_sel_update,
    input  logic                         refill,
    input  logic [CACHE_WAY-1:0]         refill_way,
    input  logic [CACHE_WAY-1:0]         way_valid,
    output logic [CACHE_WAY-1:0]         way_sel,
    output logic [$clog2(CACHE_WAY)-1:0] way_sel_idx,
    output logic                         onehot_err
);
    localparam int WayLog  = $clog2(CACHE_WAY);
    localparam int NodeNum = CACHE_WAY - 1;
    localparam int ExtW    = 2 * CACHE_WAY;
    localparam logic [WayLog:0] NodeOne = {{WayLog{1'b0}}, 1'b1};

    logic [NodeNum-1:0] tree_q [RAM_DEPTH];
    logic               err_q;
    logic [NodeNum-1:0] cur_bits;
    logic [WayLog-1:0]  sel_idx;
    logic [WayLog-1:0]  inv_idx;
    logic               inv_any;
    logic               upd_en;
    logic               err_set;
    logic [CACHE_WAY-1:0] upd_vec;

    assign cur_bits = tree_q[addr];

    // Tree bits are padded out to a power-of-two vector so the heap index needs no range check.
    function automatic logic [WayLog-1:0] plru_walk(input logic [NodeNum-1:0] bits);
        logic [ExtW-1:0]  ext;
        logic [WayLog:0]  node;
        ext  = {{(CACHE_WAY + 1){1'b0}}, bits};
        node = '0;
        for (int l = 0; l < WayLog; l++) begin
            node = (node << 1) + NodeOne + {{WayLog{1'b0}}, ext[node]};
        end
        // Leaf node n is way n-(CACHE_WAY-1); the low bits of n+1 give exactly that.
        node = node + NodeOne;
        return node[WayLog-1:0];
    endfunction

    function automatic logic [NodeNum-1:0] plru_touch(input logic [NodeNum-1:0] bits,
                                                      input logic [WayLog-1:0]  way);
        logic [ExtW-1:0]   ext;
        logic [WayLog:0]   node;
        logic [WayLog-1:0] w;
        logic              dir;
        ext  = {{(CACHE_WAY + 1){1'b0}}, bits};
        node = '0;
        w    = way;
        for (int l = 0; l < WayLog; l++) begin
            dir       = w[WayLog-1];
            ext[node] = ~dir;
            node      = (node << 1) + NodeOne + {{WayLog{1'b0}}, dir};
            w         = w << 1;
        end
        return ext[NodeNum-1:0];
    endfunction

    function automatic logic [WayLog-1:0] onehot_idx(input logic [CACHE_WAY-1:0] v);
        logic [WayLog-1:0] idx;
        idx = '0;
        for (int i = 0; i < CACHE_WAY; i++) begin
            if (v[i]) idx = WayLog'(i);
        end
        return idx;
    endfunction

    // An empty way always beats the PLRU choice; the lowest-index one wins.
    always_comb begin
        inv_any = 1'b0;
        inv_idx = '0;
        for (int i = CACHE_WAY - 1; i >= 0; i--) begin
            if (!way_valid[i]) begin
                inv_any = 1'b1;
                inv_idx = WayLog'(i);
            end
        end
        sel_idx          = inv_any ? inv_idx : plru_walk(cur_bits);
        way_sel          = '0;
        way_sel[sel_idx] = 1'b1;
    end

    assign way_sel_idx = sel_idx;

    always_comb begin
        upd_en  = 1'b0;
        err_set = 1'b0;
        upd_vec = refill_way;
        if (refill) begin
            if ($onehot(refill_way)) upd_en = 1'b1;
            else                     err_set = 1'b1;
        end else if (way_sel_update && (hit != '0)) begin
            upd_vec = hit;
            if ($onehot(hit)) upd_en = 1'b1;
            else              err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < RAM_DEPTH; s++) begin
                tree_q[s] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            if (upd_en) tree_q[addr] <= plru_touch(cur_bits, onehot_idx(upd_vec));
            if (err_set) err_q <= 1'b1;
        end
    end

    assign onehot_err = err_q;

endmodule
